// File: rtl/fp_add_arbiter_if.sv
`default_nettype none
// ============================================================================
//  fp_add_arbiter_if
//  Requester, adder and control bundle for the shared FP add/sub arbiter.
//  Rev 1.0
// ============================================================================
interface fp_add_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_sub;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_data;
    logic                  rsp_exc;
    logic [31:0]           add_a;
    logic [31:0]           add_b;
    logic                  add_sub;
    logic [31:0]           add_result;
    logic                  add_exception;
    logic                  drain;
    logic                  drained;
    logic                  busy;
    logic [NUM_REQ-1:0]    exc_sticky;
    logic [NUM_REQ-1:0]    exc_clear;

    modport slave (
        input  req_valid, req_a, req_b, req_sub, add_result, add_exception,
               drain, exc_clear,
        output req_ready, rsp_valid, rsp_data, rsp_exc, add_a, add_b, add_sub,
               drained, busy, exc_sticky
    );

    modport master (
        output req_valid, req_a, req_b, req_sub, add_result, add_exception,
               drain, exc_clear,
        input  req_ready, rsp_valid, rsp_data, rsp_exc, add_a, add_b, add_sub,
               drained, busy, exc_sticky
    );
endinterface
`default_nettype wire

// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  fp_add_arbiter
//  Round-robin sharing of one pipelined FP add/sub unit with tagged returns.
//  Rev 1.0
// ============================================================================
module fp_add_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ADDER_LATENCY = 5,
    parameter int EXC_LATENCY   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_add_arbiter_if.slave  bus
);
    localparam int                  c_idx_w   = $clog2(NUM_REQ);
    localparam int                  c_exc_dly = ADDER_LATENCY - EXC_LATENCY;
    localparam logic [c_idx_w-1:0]  c_last    = c_idx_w'(NUM_REQ - 1);
    localparam logic [c_idx_w:0]    c_num     = (c_idx_w + 1)'(NUM_REQ);

    logic [c_idx_w-1:0] r_ptr;
    logic [c_idx_w:0]   w_cand;
    logic               w_found;
    logic [c_idx_w-1:0] w_win_idx;
    logic               w_accept;
    logic [NUM_REQ-1:0] w_grant;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic               w_sel_sub;

    logic [31:0]        r_add_a;
    logic [31:0]        r_add_b;
    logic               r_add_sub;
    logic [ADDER_LATENCY:0] r_tag_vld;
    logic [c_idx_w-1:0] r_tag_idx [ADDER_LATENCY+1];
    logic               r_drained;
    logic [NUM_REQ-1:0] r_sticky;

    logic               w_out_vld;
    logic [c_idx_w-1:0] w_out_tag;
    logic               w_exc_aligned;
    logic [NUM_REQ-1:0] w_rsp_valid;
    logic               w_rsp_exc;
    logic               w_busy;

    // Search starts at the rr pointer and wraps, so the first hit is the winner.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (c_idx_w + 1)'(k);
            if (w_cand >= c_num) begin
                w_cand = w_cand - c_num;
            end
            if (!w_found && bus.req_valid[w_cand[c_idx_w-1:0]]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand[c_idx_w-1:0];
            end
        end
    end

    assign w_accept = w_found & ~bus.drain & rst_n;

    always_comb begin
        w_grant   = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_sub = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == c_idx_w'(i)) begin
                w_sel_a   = bus.req_a[i*32 +: 32];
                w_sel_b   = bus.req_b[i*32 +: 32];
                w_sel_sub = bus.req_sub[i];
                w_grant[i] = w_accept;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_add_sub <= 1'b0;
        end else if (w_accept) begin
            r_ptr     <= (w_win_idx == c_last) ? '0 : w_win_idx + 1'b1;
            r_add_a   <= w_sel_a;
            r_add_b   <= w_sel_b;
            r_add_sub <= w_sel_sub;
        end
    end

    // Tag pipeline is one deeper than the adder: the operand register is stage 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            for (int i = 0; i <= ADDER_LATENCY; i++) begin
                r_tag_idx[i] <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_accept;
            r_tag_idx[0] <= w_win_idx;
            for (int i = 1; i <= ADDER_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_idx[i] <= r_tag_idx[i-1];
            end
        end
    end

    generate
        if (c_exc_dly > 0) begin : g_exc_dly
            logic [c_exc_dly-1:0] r_exc_pipe;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_exc_pipe <= '0;
                end else begin
                    r_exc_pipe[0] <= bus.add_exception;
                    for (int i = 1; i < c_exc_dly; i++) begin
                        r_exc_pipe[i] <= r_exc_pipe[i-1];
                    end
                end
            end
            assign w_exc_aligned = r_exc_pipe[c_exc_dly-1];
        end else begin : g_exc_nodly
            assign w_exc_aligned = bus.add_exception;
        end
    endgenerate

    assign w_out_vld = r_tag_vld[ADDER_LATENCY];
    assign w_out_tag = r_tag_idx[ADDER_LATENCY];
    assign w_rsp_exc = w_out_vld & w_exc_aligned;
    assign w_busy    = (|r_tag_vld) | w_accept;

    always_comb begin
        w_rsp_valid = '0;
        if (w_out_vld) begin
            w_rsp_valid[w_out_tag] = 1'b1;
        end
    end

    // A new exception on the same bit outranks a clear arriving in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky  <= '0;
            r_drained <= 1'b0;
        end else begin
            r_sticky  <= (r_sticky & ~bus.exc_clear) | (w_rsp_valid & {NUM_REQ{w_rsp_exc}});
            r_drained <= bus.drain & ~w_busy;
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_data   = w_out_vld ? bus.add_result : 32'd0;
    assign bus.rsp_exc    = w_rsp_exc;
    assign bus.add_a      = r_add_a;
    assign bus.add_b      = r_add_b;
    assign bus.add_sub    = r_add_sub;
    assign bus.busy       = w_busy;
    assign bus.drained    = r_drained;
    assign bus.exc_sticky = r_sticky;
endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_fp_add_arbiter
//  Directed bench with a behavioural 5-stage adder for fp_add_arbiter.
//  Rev 1.0
// ============================================================================
module tb_fp_add_arbiter;
    localparam int NR  = 4;
    localparam int LAT = 5;
    localparam int EXL = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_add_arbiter_if #(.NUM_REQ(NR)) bus ();

    fp_add_arbiter #(
        .NUM_REQ       (NR),
        .ADDER_LATENCY (LAT),
        .EXC_LATENCY   (EXL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] fv [0:8];

    function automatic real to_real(input logic [31:0] x);
        if (x[30:23] == 8'd0) return 0.0;
        return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0});
    endfunction

    // Adequate for the normal, exactly representable values used here.
    function automatic logic [32:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic sub);
        real r;
        logic [63:0] d;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {1'b1, 32'd0};
        r = sub ? to_real(a) - to_real(b) : to_real(a) + to_real(b);
        if (r == 0.0) return 33'd0;
        d = $realtobits(r);
        return {1'b0, d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    logic [32:0] w_fr;
    logic [31:0] res_pipe [LAT];
    logic        exc_s1;
    assign w_fr = fadd(bus.add_a, bus.add_b, bus.add_sub);

    always @(posedge clk) begin
        res_pipe[0] <= w_fr[31:0];
        for (int i = 1; i < LAT; i++) res_pipe[i] <= res_pipe[i-1];
        exc_s1 <= w_fr[32];
    end
    assign bus.add_result    = res_pipe[LAT-1];
    assign bus.add_exception = exc_s1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ops();
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*32 +: 32] = fv[i+1];
            bus.req_b[i*32 +: 32] = fv[1];
            bus.req_sub[i]        = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Returns while the response is still visible.
    task automatic issue_one(input int idx, input logic [31:0] a, input logic [31:0] b,
                             input logic sub, input logic [31:0] exp_d, input logic exp_e,
                             input string tag);
        int lat;
        bus.req_valid          = '0;
        bus.req_valid[idx]     = 1'b1;
        bus.req_a[idx*32 +: 32] = a;
        bus.req_b[idx*32 +: 32] = b;
        bus.req_sub[idx]       = sub;
        #1;
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(1) << idx);
        step();
        bus.req_valid = '0;
        chk({tag, "_add_a"}, bus.add_a, a);
        lat = 0;
        while (bus.rsp_valid == '0 && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(LAT));
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(1) << idx);
        chk({tag, "_rsp_data"}, bus.rsp_data, exp_d);
        chk({tag, "_rsp_exc"}, 32'(bus.rsp_exc), 32'(exp_e));
    endtask

    initial begin
        int k;
        int seen;
        fv = '{32'h0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = '0;
        bus.drain     = 1'b0;
        bus.exc_clear = '0;

        // Reset state, with requests pending to show grants are held off
        repeat (3) @(posedge clk);
        #1;
        bus.req_valid = 4'hF;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_drained", 32'(bus.drained), 32'd0);
        chk("rst_sticky", 32'(bus.exc_sticky), 32'd0);
        chk("rst_add_a", bus.add_a, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        bus.req_valid = '0;
        rst_n = 1'b1;
        step();

        // Single request: 1.0 + 2.0 = 3.0 on requester 2
        issue_one(2, fv[1], fv[2], 1'b0, fv[3], 1'b0, "t1");
        step();
        chk("t1_pulse_once", 32'(bus.rsp_valid), 32'd0);
        chk("t1_idle_data", bus.rsp_data, 32'd0);
        chk("t1_idle_exc", 32'(bus.rsp_exc), 32'd0);

        // All requesters continuously valid, pointer from 0
        do_reset();
        load_ops();
        for (int j = 0; j < 14; j++) begin
            bus.req_valid = (j < 8) ? 4'hF : 4'h0;
            #1;
            chk("t2_ready", 32'(bus.req_ready), (j < 8) ? (32'(1) << (j % 4)) : 32'd0);
            k = j - 6;
            if (k >= 0 && k < 8) begin
                chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'(1) << (k % 4));
                chk("t2_rsp_data", bus.rsp_data, fv[(k % 4) + 2]);
            end else begin
                chk("t2_rsp_idle", 32'(bus.rsp_valid), 32'd0);
            end
            step();
        end

        // Subtract: 3.0 - 1.0 = 2.0 on requester 1
        issue_one(1, fv[3], fv[1], 1'b1, fv[2], 1'b0, "t3");
        step();

        // Exception from infinity operand, sticky set/clear, set wins over clear
        issue_one(3, 32'h7F800000, fv[1], 1'b0, 32'd0, 1'b1, "t4");
        step();
        chk("t4_sticky_set", 32'(bus.exc_sticky), 32'h8);
        bus.exc_clear = 4'h8;
        step();
        bus.exc_clear = 4'h0;
        chk("t4_sticky_clr", 32'(bus.exc_sticky), 32'h0);
        issue_one(3, 32'h7F800000, fv[1], 1'b0, 32'd0, 1'b1, "t4b");
        bus.exc_clear = 4'h8;
        step();
        bus.exc_clear = 4'h0;
        chk("t4_set_wins", 32'(bus.exc_sticky), 32'h8);

        // Drain with three operations in flight
        load_ops();
        for (int j = 0; j < 11; j++) begin
            bus.req_valid = (j < 3) ? 4'h7 : 4'hF;
            bus.drain     = (j >= 3);
            #1;
            chk("t5_ready", 32'(bus.req_ready), (j < 3) ? (32'(1) << j) : 32'd0);
            chk("t5_busy", 32'(bus.busy), 32'(j <= 8));
            chk("t5_drained", 32'(bus.drained), 32'(j >= 10));
            k = j - 6;
            if (k >= 0 && k < 3) begin
                chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'(1) << k);
                chk("t5_rsp_data", bus.rsp_data, fv[k + 2]);
            end
            step();
        end
        bus.drain = 1'b0;
        #1;
        chk("t5_resume", 32'(bus.req_ready), 32'h8);
        step();
        bus.req_valid = '0;
        repeat (8) step();

        // Reset with operations in flight
        bus.req_valid = 4'h7;
        repeat (3) step();
        chk("t6_sticky_pre", 32'(bus.exc_sticky), 32'h8);
        rst_n = 1'b0;
        #1;
        chk("t6_ready", 32'(bus.req_ready), 32'd0);
        chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t6_rsp_data", bus.rsp_data, 32'd0);
        chk("t6_rsp_exc", 32'(bus.rsp_exc), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_drained", 32'(bus.drained), 32'd0);
        chk("t6_sticky", 32'(bus.exc_sticky), 32'd0);
        chk("t6_add_a", bus.add_a, 32'd0);
        chk("t6_add_b", bus.add_b, 32'd0);
        chk("t6_add_sub", 32'(bus.add_sub), 32'd0);
        bus.req_valid = '0;
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int j = 0; j < 12; j++) begin
            step();
            if (bus.rsp_valid != '0) seen++;
        end
        chk("t6_no_rsp_after_rst", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
